// File: rtl/mult_div.sv
// mult_div: iterative signed/unsigned multiply-divide unit producing the HI/LO pair
// Ports: clk, reset (sync, active-high); start/op/a/b request an operation (op 00 MULT,
// 01 MULTU, 10 DIV, 11 DIVU); hi/lo hold the result; busy while running; done and
// div_zero pulse for one cycle when a result (or a zero-divisor abort) is ready.
module mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic is_div, q_neg, r_neg, zf;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem, m, a_mag, b_mag;
    logic [WIDTH:0] sum, shl;
    logic sgn, ge;
    assign sgn = ~op[0];
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    // multiply: add multiplicand into the upper half when the next multiplier bit is set
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    // divide: partial remainder shifted left with the next dividend bit, MSB first
    assign shl = {rem, acc[WIDTH-1]};
    assign ge = shl >= {1'b0, m};
    assign busy = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ((op[1] && b == '0) ? FIX : CALC) : IDLE;
            CALC:    state_nx = (cnt == CW'(1)) ? FIX : CALC;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    is_div <= op[1];
                    zf     <= op[1] && b == '0;
                    q_neg  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg  <= sgn && a[WIDTH-1];
                    m      <= op[1] ? b_mag : a_mag;
                    acc    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    rem    <= '0;
                    cnt    <= CW'(WIDTH);
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        rem              <= ge ? WIDTH'(shl - {1'b0, m}) : shl[WIDTH-1:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ge};
                    end else begin
                        acc <= {sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= zf;
                    if (!zf && is_div) begin
                        lo <= q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= r_neg ? -rem : rem;
                    end else if (!zf) begin
                        {hi, lo} <= q_neg ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
